// File: rtl/w0rm_demo.sv
// rtl/w0rm_demo.sv - W0RM board demo: switch-seeded, tick-paced LED patterns (optional macro W0RM_DEMO_HEARTBEAT_EN)
module w0rm_demo #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       sysclk_p,
   input  logic       sysclk_n,
   input  logic       cpu_reset,
   input  logic [7:0] gpio_a,
   output logic [7:0] gpio_b,
   input  logic [7:0] gpio_c
);

   localparam int unsigned    PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [2:0] MODE_ROTATE = 3'd0;
   localparam logic [2:0] MODE_COUNT  = 3'd1;
   localparam logic [2:0] MODE_ECHO   = 3'd2;
   localparam logic [2:0] MODE_ACC    = 3'd3;
   localparam logic [2:0] MODE_BOUNCE = 3'd4;
   localparam logic [2:0] MODE_INV    = 3'd5;

   // The negative clock leg and the upper selector bits exist only for pin mapping.
   logic unused_pins;
   assign unused_pins = ^{sysclk_n, gpio_c[7:3]};

   logic          clk;
   logic          rst_n;
   assign clk   = sysclk_p;
   assign rst_n = cpu_reset;

   logic [7:0]    sw_s1_q, sw_q;
   logic [2:0]    mode_s1_q, mode_q;
   logic [2:0]    last_mode_q, last_mode_d;
   logic          init_q, init_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    led_q, led_d;
   logic          dir_q, dir_d;      // 0 = moving left (towards bit 7), 1 = moving right
   logic          entry;
   logic          tick;

   // Two-flop synchronisers for the asynchronous switch and mode inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1_q   <= '0;
         sw_q      <= '0;
         mode_s1_q <= '0;
         mode_q    <= '0;
      end else begin
         sw_s1_q   <= gpio_a;
         sw_q      <= sw_s1_q;
         mode_s1_q <= gpio_c[2:0];
         mode_q    <= mode_s1_q;
      end
   end

   // Mode entry, prescaler and per-mode LED update; entry always wins over a tick.
   always_comb begin
      entry       = init_q | (mode_q != last_mode_q);
      tick        = ~entry & (presc_q == TICK_LAST);
      presc_d     = (entry | tick) ? '0 : presc_q + PW'(1);
      last_mode_d = last_mode_q;
      init_d      = init_q;
      led_d       = led_q;
      dir_d       = dir_q;
      if (entry) begin
         init_d      = 1'b0;
         last_mode_d = mode_q;
         case (mode_q)
            MODE_ROTATE: led_d = (sw_q == 8'h00) ? 8'h01 : sw_q;
            MODE_COUNT:  led_d = 8'h00;
            MODE_ECHO:   led_d = sw_q;
            MODE_ACC:    led_d = 8'h00;
            MODE_BOUNCE: begin
               led_d = 8'h01;
               dir_d = 1'b0;
            end
            MODE_INV:    led_d = ~sw_q;
            default:     led_d = led_q;
         endcase
      end else begin
         case (mode_q)
            MODE_ROTATE: if (tick) led_d = {led_q[0], led_q[7:1]};
            MODE_COUNT:  if (tick) led_d = led_q + 8'd1;
            MODE_ECHO:   led_d = sw_q;
            MODE_ACC:    if (tick) led_d = led_q + sw_q;
            MODE_BOUNCE: begin
               if (tick) begin
                  if (!dir_q) begin
                     led_d = led_q << 1;
                     if (led_q == 8'h40) dir_d = 1'b1;
                  end else begin
                     led_d = led_q >> 1;
                     if (led_q == 8'h02) dir_d = 1'b0;
                  end
               end
            end
            MODE_INV:    led_d = ~sw_q;
            default:     led_d = led_q;
         endcase
      end
   end

   // Pattern state registers; reset arms the init flag so the first clock performs an entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q      <= 1'b1;
         last_mode_q <= '0;
         presc_q     <= '0;
         led_q       <= '0;
         dir_q       <= 1'b0;
      end else begin
         init_q      <= init_d;
         last_mode_q <= last_mode_d;
         presc_q     <= presc_d;
         led_q       <= led_d;
         dir_q       <= dir_d;
      end
   end

`ifdef W0RM_DEMO_HEARTBEAT_EN
   logic hb_q, hb_d;
   assign hb_d = hb_q ^ tick;

   // Heartbeat flips on every tick regardless of mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hb_q <= 1'b0;
      else        hb_q <= hb_d;
   end

   assign gpio_b = {hb_q, led_q[6:0]};
`else
   assign gpio_b = led_q;
`endif

endmodule

// File: tb/tb_w0rm_demo.sv
// tb/tb_w0rm_demo.sv - randomized, model-checked bench for w0rm_demo
`timescale 1ns/100ps
module tb_w0rm_demo;

   localparam int TICK_DIV = 4;
`ifdef W0RM_DEMO_HEARTBEAT_EN
   localparam bit         HB    = 1'b1;
   localparam logic [7:0] LMASK = 8'h7F;
`else
   localparam bit         HB    = 1'b0;
   localparam logic [7:0] LMASK = 8'hFF;
`endif

   logic       sysclk_p  = 1'b0;
   logic       sysclk_n  = 1'b1;
   logic       cpu_reset = 1'b0;
   logic [7:0] gpio_a    = 8'h00;
   logic [7:0] gpio_c    = 8'h00;
   logic [7:0] gpio_b;

   int checks = 0;
   int errors = 0;

   w0rm_demo #(.TICK_DIV(TICK_DIV)) dut (
      .sysclk_p  (sysclk_p),
      .sysclk_n  (sysclk_n),
      .cpu_reset (cpu_reset),
      .gpio_a    (gpio_a),
      .gpio_b    (gpio_b),
      .gpio_c    (gpio_c)
   );

   always #2.5 begin
      sysclk_p = ~sysclk_p;
      sysclk_n = ~sysclk_n;
   end

   // Behavioural model: cycles and ticks counted since the last mode entry.
   logic [7:0] m_sw1 = 0, m_sw2 = 0, m_led = 0, m_out = 0, sw;
   logic [2:0] m_md1 = 0, m_md2 = 0, m_last = 0, md;
   bit         m_init = 1, m_hb = 0, tk;
   int         m_since = 0, m_ticks = 0, p;

   initial begin
      forever begin
         @(posedge sysclk_p or negedge cpu_reset);
         if (!cpu_reset) begin
            m_sw1 = 0; m_sw2 = 0; m_md1 = 0; m_md2 = 0; m_last = 0;
            m_init = 1; m_since = 0; m_ticks = 0; m_led = 0; m_hb = 0;
         end else begin
            sw = m_sw2; md = m_md2;
            m_sw2 = m_sw1; m_sw1 = gpio_a;
            m_md2 = m_md1; m_md1 = gpio_c[2:0];
            if (m_init || md != m_last) begin
               m_init = 0; m_last = md; m_since = 0; m_ticks = 0;
               case (md)
                  3'd0: m_led = (sw == 0) ? 8'h01 : sw;
                  3'd1, 3'd3: m_led = 8'h00;
                  3'd2: m_led = sw;
                  3'd4: m_led = 8'h01;
                  3'd5: m_led = ~sw;
                  default: ;
               endcase
            end else begin
               m_since++;
               tk = (m_since % TICK_DIV) == 0;
               if (tk) begin
                  m_ticks++;
                  m_hb = ~m_hb;
               end
               case (md)
                  3'd0: if (tk) m_led = (m_led >> 1) | (m_led << 7);
                  3'd1: m_led = 8'(m_ticks % 256);
                  3'd2: m_led = sw;
                  3'd3: if (tk) m_led = 8'((m_led + sw) % 256);
                  3'd4: begin
                     p = m_ticks % 14;
                     m_led = (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
                  end
                  3'd5: m_led = ~sw;
                  default: ;
               endcase
            end
         end
         m_out = HB ? {m_hb, m_led[6:0]} : m_led;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge sysclk_p);
         checks++;
         if (gpio_b !== m_out) begin
            errors++;
            $display("FAIL model t=%0t: gpio_b=0x%02h expected 0x%02h", $time, gpio_b, m_out);
         end
      end
   end

   task automatic lit_check(input logic [7:0] lit, input string name);
      checks++;
      if ((gpio_b & LMASK) !== (lit & LMASK)) begin
         errors++;
         $display("FAIL %s: gpio_b=0x%02h expected 0x%02h", name, gpio_b, lit);
      end
   endtask

   // Wait (bounded) for the next visible LED change, then compare with a literal.
   task automatic expect_next(input logic [7:0] lit, input string name, output int n);
      logic [7:0] prev;
      bit seen;
      prev = gpio_b & LMASK;
      seen = 0;
      n = 0;
      while (!seen && n < 4 * TICK_DIV) begin
         @(negedge sysclk_p);
         n++;
         if ((gpio_b & LMASK) != prev) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no change in %0d cycles, gpio_b=0x%02h expected 0x%02h", name, n, gpio_b, lit);
      end else begin
         lit_check(lit, name);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] c);
      @(posedge sysclk_p);
      #1;
      gpio_a = a;
      gpio_c = c;
   endtask

   task automatic settle;
      repeat (3) @(posedge sysclk_p);
      @(negedge sysclk_p);
   endtask

   initial begin
      int n;
      logic [7:0] v;
      gpio_a = 8'h80;
      #6 lit_check(8'h00, "reset_hold");
      #5 cpu_reset = 1'b1;
      @(negedge sysclk_p);
      lit_check(8'h01, "rotate_entry");
      v = 8'h80;
      for (int i = 0; i < 9; i++) begin
         expect_next(v, "rotate_step", n);
         if (i == 1) begin
            checks++;
            if (n != TICK_DIV) begin
               errors++;
               $display("FAIL tick_period: %0d cycles expected %0d", n, TICK_DIV);
            end
         end
         v = {v[0], v[7:1]};
      end

      drive(8'h00, 8'h01);
      settle();
      lit_check(8'h00, "count_entry");
      for (int i = 1; i <= 256; i++) begin
         v = 8'(i);
         expect_next(v, "count_step", n);
      end

      drive(8'h5A, 8'h02);
      settle();
      lit_check(8'h5A, "echo_5a");
      drive(8'hA5, 8'h02);
      settle();
      lit_check(8'hA5, "echo_a5");
      drive(8'h5A, 8'h05);
      settle();
      lit_check(8'hA5, "inv_echo");

      drive(8'h80, 8'h03);
      settle();
      lit_check(8'h00, "acc_entry");
      expect_next(8'h80, "acc_80_a", n);
      expect_next(8'h00, "acc_80_b", n);
      expect_next(8'h80, "acc_80_c", n);
      drive(8'h80, 8'h07);
      repeat (4) @(posedge sysclk_p);
      drive(8'h03, 8'h03);
      settle();
      lit_check(8'h00, "acc_reentry");
      for (int i = 1; i <= 85; i++) begin
         v = 8'(3 * i);
         expect_next(v, "acc_step", n);
      end
      expect_next(8'h02, "acc_wrap", n);

      drive(8'h00, 8'h04);
      settle();
      lit_check(8'h01, "bounce_entry");
      for (int i = 1; i <= 15; i++) begin
         p = i % 14;
         v = (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
         expect_next(v, "bounce_step", n);
      end
      drive(8'h00, 8'h06);
      repeat (20) @(posedge sysclk_p);

      drive(8'h80, 8'h00);
      repeat (10) @(posedge sysclk_p);
      #1 cpu_reset = 1'b0;
      #1 lit_check(8'h00, "async_reset");
      repeat (2) @(posedge sysclk_p);
      @(negedge sysclk_p);
      cpu_reset = 1'b1;
      @(negedge sysclk_p);
      lit_check(8'h01, "restart_entry");
      expect_next(8'h80, "restart_step", n);

      for (int i = 0; i < 60; i++) begin
         drive(8'($urandom), 8'($urandom_range(0, 255)));
         repeat ($urandom_range(1, 40)) @(posedge sysclk_p);
      end
      @(negedge sysclk_p);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
